// File: rtl/cpu_types_pkg.sv
// Shared fetch-stage types: next-PC source encoding and PC arithmetic constants.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    SEQ      = 3'd0,
    JR       = 3'd1,
    JUMP     = 3'd2,
    BRANCH   = 3'd3,
    RET      = 3'd4,
    REDIRECT = 3'd5
  } pc_src_t;

  // Sequential instruction stride in bytes.
  localparam int PC_INCR     = 4;
  // Lowest PC bit kept from the sequential PC on a region jump.
  localparam int JUMP_HI_LSB = 28;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. The top pointer names the newest entry;
// a push writes the slot after it, so a full stack silently overwrites the
// oldest entry. Entries themselves are never reset, only pointer/count/flags.
module pc_ras #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         ret,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         hit,
  output logic                         ovf,
  output logic                         unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [PTR_W-1:0] top_inc;
  logic [PTR_W-1:0] top_dec;
  logic             empty;
  logic             pop;

  assign top_inc  = top + 1'b1;
  assign top_dec  = top - 1'b1;
  assign empty    = (count == '0);
  assign pop      = ret & ~empty;
  assign hit      = pop;
  assign top_data = mem[top];

  // Entry storage: written on push only, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[top_inc] <= push_data;
  end

  // Pointer, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      top <= top_inc;
      if (count == FULL) ovf   <= 1'b1;
      else               count <= count + 1'b1;
    end else if (pop) begin
      top   <= top_dec;
      count <= count - 1'b1;
    end else if (ret) begin
      unf <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with next-PC select and return-address stack.
// Optional macro PC_ALIGN_CHECK_EN adds a misalign output and forces the
// loaded PC to word alignment.
module pc_unit_ras
  import cpu_types_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        pc_en,
  input  logic [2:0]                  pc_src,
  input  logic                        link,
  input  logic [PC_W-1:0]             rdat1,
  input  logic [25:0]                 immediate26,
  input  logic                        branch_flag,
  input  logic [PC_W-1:0]             branch_addr,
  input  logic [PC_W-1:0]             redirect_addr,
  output logic [PC_W-1:0]             imemaddr,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_hit,
  output logic                        ras_ovf,
  output logic                        ras_unf
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                        misalign
`endif
);

  // Bits below JUMP_HI_LSB come from the jump field; bits above stay with seq.
  localparam logic [PC_W-1:0] LO_MASK = PC_W'((64'd1 << JUMP_HI_LSB) - 64'd1);

  pc_src_t         src;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_load;
  logic [PC_W-1:0] ras_top;
  logic            push;
  logic            ret;

  assign src      = pc_src_t'(pc_src);
  assign seq      = pc + PC_W'(PC_INCR);
  assign jump_tgt = (seq & ~LO_MASK) | PC_W'({immediate26, 2'b00});
  assign push     = pc_en & (src == JUMP) & link;
  assign ret      = pc_en & (src == RET);
  assign imemaddr = pc;

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .ret       (ret),
    .push_data (seq),
    .top_data  (ras_top),
    .count     (ras_count),
    .hit       (ras_hit),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

  // Next-PC select; unused encodings hold the current PC.
  always_comb begin
    pc_next = pc;
    case (src)
      SEQ:      pc_next = seq;
      JR:       pc_next = rdat1;
      JUMP:     pc_next = jump_tgt;
      BRANCH:   pc_next = branch_flag ? branch_addr : seq;
      RET:      pc_next = ras_hit ? ras_top : rdat1;
      REDIRECT: pc_next = redirect_addr;
      default:  pc_next = pc;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  assign misalign = pc_en & (pc_next[1:0] != 2'b00);
  assign pc_load  = misalign ? {pc_next[PC_W-1:2], 2'b00} : pc_next;
`else
  assign pc_load  = pc_next;
`endif

  // PC register: reset wins over stall, stall freezes everything.
  always_ff @(posedge CLK) begin
    if (RST)        pc <= RESET_VEC;
    else if (pc_en) pc <= pc_load;
  end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parameterised program counter unit for the fetch stage. Drives the instruction-memory address and selects the next PC from sequential, register, jump, branch, return and redirect sources. Adds stall gating, a programmable reset vector and a circular return-address stack (RAS), so returns are predicted without waiting on the register file.

Parameters:
PC_W, 32, PC and address width in bits (>= 28).
RESET_VEC, 0, PC value after reset.
RAS_DEPTH, 4, RAS entries (power of 2, >= 2).

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous, active-high reset
pc_en  in  1  1 = PC and RAS may update; 0 = stall, all state held
pc_src  in  3  pc_src_t: SEQ=0, JR=1, JUMP=2, BRANCH=3, RET=4, REDIRECT=5
link  in  1  with JUMP: JAL, push return address
rdat1  in  PC_W  register operand for JR and RET fallback
immediate26  in  26  jump target field
branch_flag  in  1  branch taken
branch_addr  in  PC_W  branch target
redirect_addr  in  PC_W  flush/exception target
imemaddr  out  PC_W  current PC
ras_count  out  clog2(RAS_DEPTH)+1  valid entries
ras_hit  out  1  comb: RET this cycle used a RAS entry
ras_ovf  out  1  sticky: push when full
ras_unf  out  1  sticky: RET when empty

Behaviour:
- Reset (RST=1 at edge): PC=RESET_VEC, ras_count=0, top pointer=0, ras_ovf=0, ras_unf=0. Entries are not cleared. RST overrides pc_en. Reset mid-stall or mid-RET discards the operation.
- imemaddr = PC (registered, zero comb latency). PC_next takes effect one cycle after the selecting inputs.
- PC_next, with seq = PC+4 (mod 2^PC_W):
  - SEQ: seq.
  - JR: rdat1.
  - JUMP: {seq[PC_W-1:28], immediate26, 2'b00}.
  - BRANCH: branch_flag ? branch_addr : seq.
  - RET: ras_count>0 ? RAS top : rdat1.
  - REDIRECT: redirect_addr.
  - Codes 6–7: hold PC.
- pc_en=0: PC, RAS, pointers and flags all unchanged. All inputs are ignored.
- Push: pc_en & pc_src==JUMP & link. Writes seq to the slot after top, then top++ (wraps modulo RAS_DEPTH) and ras_count++.
- Full push: ras_count saturates at RAS_DEPTH, the oldest entry is overwritten and ras_ovf is set.
- Pop: pc_en & pc_src==RET & ras_count>0. Reads top, then top-- (wraps) and ras_count--. ras_hit=1.
- Empty RET: PC_next=rdat1, no pointer change, ras_hit=0, ras_unf set.
- Push and pop are mutually exclusive by encoding. link is ignored unless pc_src==JUMP.
- REDIRECT leaves the RAS intact.
- ras_ovf and ras_unf clear only on RST.
- All arithmetic is unsigned PC_W bits, with wrap at 2^PC_W.

Optional Feature:
Macro PC_ALIGN_CHECK_EN.
- Defined: adds output misalign (1 bit). It is set combinationally when pc_en and PC_next[1:0] != 0.
- On misalign, PC is loaded with PC_next[PC_W-1:2],2'b00 instead.
- Undefined: no port; PC_next is loaded unmodified.

Decomposition:
- cpu_types_pkg: pc_src_t enum (3 bits), PC_INCR=4, JUMP_HI_LSB=28.
- Sub-module pc_ras: circular stack with push, pop, top, count, ovf, unf, parameterised by PC_W and RAS_DEPTH.
- The top level holds the PC register and the next-PC mux.

Test Plan:
1. Reset with RESET_VEC=0x400, then 3 cycles of SEQ with pc_en=1 -> imemaddr steps 0x400, 0x404, 0x408, 0x40C.
2. At PC=0x1000, JUMP link=1 imm26=0x40 -> PC=0x100, ras_count=1. Then RET -> PC=0x1004, ras_hit=1, ras_count=0.
3. RAS_DEPTH=4: five JAL from PCs A..E -> ras_ovf=1, ras_count=4. Four RETs return E+4, D+4, C+4, B+4. A fifth RET with rdat1=0x2000 -> PC=0x2000, ras_unf=1.
4. BRANCH with branch_flag=0 at PC=0x20 -> 0x24. With branch_flag=1, branch_addr=0x80 -> 0x80.
5. pc_en=0 for 3 cycles with pc_src=JUMP, link=1 -> PC and ras_count unchanged. RST=1 during the stall -> PC=RESET_VEC, count=0.
6. With PC_ALIGN_CHECK_EN: JR rdat1=0x1002 -> misalign=1, PC=0x1000. PC=0xFFFFFFFC with SEQ -> PC=0x0.
